// File: rtl/ramb_sp_bw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ramb_sp_bw : single-port byte-write block RAM with parity and bulk clear   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ramb_sp_bw #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 9,
    parameter string WRITE_MODE = "WRITE_FIRST",
    parameter int    DO_REG     = 0,
    parameter logic [DATA_WIDTH+DATA_WIDTH/8-1:0] INIT      = '0,
    parameter logic [DATA_WIDTH+DATA_WIDTH/8-1:0] SRVAL     = '0,
    parameter logic [DATA_WIDTH+DATA_WIDTH/8-1:0] CLEAR_VAL = '0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic                    SSR,
    input  logic [DATA_WIDTH/8-1:0] WE,
    input  logic [ADDR_WIDTH-1:0]   ADDR,
    input  logic [DATA_WIDTH-1:0]   DI,
    input  logic [DATA_WIDTH/8-1:0] DIP,
    input  logic                    REGCE,
    input  logic                    CLR,
    output logic [DATA_WIDTH-1:0]   DO,
    output logic [DATA_WIDTH/8-1:0] DOP,
    output logic                    BUSY
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int WORD_W    = DATA_WIDTH + NUM_BYTES;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit MODE_RF   = (WRITE_MODE == "READ_FIRST");
    localparam bit MODE_NC   = (WRITE_MODE == "NO_CHANGE");

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic [WORD_W-1:0]       mem_q [DEPTH];
    logic [WORD_W-1:0]       latch_q;
    logic [WORD_W-1:0]       latch_d;
    logic [WORD_W-1:0]       rd_word;
    logic [WORD_W-1:0]       wr_word;
    logic [WORD_W-1:0]       out_word;
    logic                    port_act;

    assign port_act = (state_q == ST_IDLE) && EN;

    // Word layout: data in the low DATA_WIDTH bits, one parity bit per lane above.
    always_comb begin
        rd_word = mem_q[ADDR];
        wr_word = rd_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (WE[b]) begin
                wr_word[8*b +: 8]       = DI[8*b +: 8];
                wr_word[DATA_WIDTH + b] = DIP[b];
            end
        end
    end

    always_comb begin
        latch_d = latch_q;
        if (port_act) begin
            if (SSR) begin
                latch_d = SRVAL;
            end else if (WE == '0) begin
                latch_d = rd_word;
            end else if (MODE_RF) begin
                latch_d = rd_word;
            end else if (!MODE_NC) begin
                latch_d = wr_word;
            end
        end
    end

    // Contents are deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (state_q == ST_SWEEP) begin
            mem_q[cnt_q] <= CLEAR_VAL;
        end else if (EN && (WE != '0)) begin
            mem_q[ADDR] <= wr_word;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CLR) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            latch_q <= INIT;
        end else begin
            latch_q <= latch_d;
        end
    end

    generate
        if (DO_REG != 0) begin : g_doreg
            logic [WORD_W-1:0] oreg_q;
            logic [WORD_W-1:0] oreg_d;

            always_comb begin
                oreg_d = oreg_q;
                if ((state_q == ST_IDLE) && REGCE) begin
                    oreg_d = SSR ? SRVAL : latch_q;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    oreg_q <= INIT;
                end else begin
                    oreg_q <= oreg_d;
                end
            end

            assign out_word = oreg_q;
        end else begin : g_nodoreg
            logic unused_regce;
            assign unused_regce = REGCE;
            assign out_word     = latch_q;
        end
    endgenerate

    assign DO   = out_word[DATA_WIDTH-1:0];
    assign DOP  = out_word[WORD_W-1:DATA_WIDTH];
    assign BUSY = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ramb_sp_bw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ramb_sp_bw : bench for ramb_sp_bw across write modes and DO_REG         |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ramb_sp_bw;

    localparam logic [35:0] INIT_V  = 36'hA_1234_5678;
    localparam logic [35:0] SRVAL_V = 36'h5_5A5A_A5A5;
    localparam logic [35:0] CLR_V   = 36'h3_C1EA_C1EA;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic        SSR = 1'b0;
    logic [3:0]  WE = 4'h0;
    logic [3:0]  ADDR = 4'h0;
    logic [31:0] DI = 32'h0;
    logic [3:0]  DIP = 4'h0;
    logic        REGCE = 1'b0;
    logic        CLR = 1'b0;

    logic [31:0] do_wf, do_rf, do_nc, do_rg;
    logic [3:0]  dop_wf, dop_rf, dop_nc, dop_rg;
    logic        busy_wf, busy_rf, busy_nc, busy_rg;

    int checks = 0;
    int errors = 0;

    // Reference state: one shared memory image, one latch per write mode, the output register.
    logic [35:0] mem_m [16];
    logic [35:0] lat_wf, lat_rf, lat_nc, rg_m;
    bit          sw_m;
    int          cnt_m;

    always #5 CLK = ~CLK;

    ramb_sp_bw #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_MODE("WRITE_FIRST"), .DO_REG(0),
                 .INIT(INIT_V), .SRVAL(SRVAL_V), .CLEAR_VAL(CLR_V)) u_wf (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SSR(SSR), .WE(WE), .ADDR(ADDR), .DI(DI),
        .DIP(DIP), .REGCE(REGCE), .CLR(CLR), .DO(do_wf), .DOP(dop_wf), .BUSY(busy_wf));

    ramb_sp_bw #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_MODE("READ_FIRST"), .DO_REG(0),
                 .INIT(INIT_V), .SRVAL(SRVAL_V), .CLEAR_VAL(CLR_V)) u_rf (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SSR(SSR), .WE(WE), .ADDR(ADDR), .DI(DI),
        .DIP(DIP), .REGCE(REGCE), .CLR(CLR), .DO(do_rf), .DOP(dop_rf), .BUSY(busy_rf));

    ramb_sp_bw #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_MODE("NO_CHANGE"), .DO_REG(0),
                 .INIT(INIT_V), .SRVAL(SRVAL_V), .CLEAR_VAL(CLR_V)) u_nc (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SSR(SSR), .WE(WE), .ADDR(ADDR), .DI(DI),
        .DIP(DIP), .REGCE(REGCE), .CLR(CLR), .DO(do_nc), .DOP(dop_nc), .BUSY(busy_nc));

    ramb_sp_bw #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_MODE("WRITE_FIRST"), .DO_REG(1),
                 .INIT(INIT_V), .SRVAL(SRVAL_V), .CLEAR_VAL(CLR_V)) u_rg (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SSR(SSR), .WE(WE), .ADDR(ADDR), .DI(DI),
        .DIP(DIP), .REGCE(REGCE), .CLR(CLR), .DO(do_rg), .DOP(dop_rg), .BUSY(busy_rg));

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("do_write_first", {dop_wf, do_wf}, lat_wf);
        check("do_read_first",  {dop_rf, do_rf}, lat_rf);
        check("do_no_change",   {dop_nc, do_nc}, lat_nc);
        check("do_out_reg",     {dop_rg, do_rg}, rg_m);
        check("busy_wf", {35'h0, busy_wf}, {35'h0, sw_m});
        check("busy_rg", {35'h0, busy_rg}, {35'h0, sw_m});
    endtask

    task automatic model_reset();
        lat_wf = INIT_V;
        lat_rf = INIT_V;
        lat_nc = INIT_V;
        rg_m   = INIT_V;
        sw_m   = 1'b0;
        cnt_m  = 0;
    endtask

    // One clock edge worth of behaviour, taken straight from the operating rules.
    task automatic model_edge(input logic en, input logic ssr, input logic [3:0] we,
                              input logic [3:0] addr, input logic [31:0] di,
                              input logic [3:0] dip, input logic regce, input logic clr);
        logic [35:0] old_w, new_w;
        if (sw_m) begin
            mem_m[cnt_m] = CLR_V;
            if (cnt_m == 15) begin
                sw_m  = 1'b0;
                cnt_m = 0;
            end else begin
                cnt_m++;
            end
        end else begin
            old_w = mem_m[addr];
            new_w = old_w;
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    new_w[8*b +: 8] = di[8*b +: 8];
                    new_w[32 + b]   = dip[b];
                end
            end
            if (regce) rg_m = ssr ? SRVAL_V : lat_wf;
            if (en) begin
                if (we != 4'h0) mem_m[addr] = new_w;
                if (ssr) begin
                    lat_wf = SRVAL_V;
                    lat_rf = SRVAL_V;
                    lat_nc = SRVAL_V;
                end else if (we == 4'h0) begin
                    lat_wf = old_w;
                    lat_rf = old_w;
                    lat_nc = old_w;
                end else begin
                    lat_wf = new_w;
                    lat_rf = old_w;
                end
            end
            if (clr) begin
                sw_m  = 1'b1;
                cnt_m = 0;
            end
        end
    endtask

    task automatic cyc(input logic en, input logic ssr, input logic [3:0] we,
                       input logic [3:0] addr, input logic [31:0] di, input logic [3:0] dip,
                       input logic regce, input logic clr);
        @(negedge CLK);
        EN = en; SSR = ssr; WE = we; ADDR = addr; DI = di; DIP = dip; REGCE = regce; CLR = clr;
        model_edge(en, ssr, we, addr, di, dip, regce, clr);
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b1, 1'b0, 4'h0, a, 32'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic fill_all();
        for (int a = 0; a < 16; a++)
            cyc(1'b1, 1'b0, 4'hF, 4'(a), $urandom, 4'($urandom_range(15)), 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        for (int a = 0; a < 16; a++) mem_m[a] = 36'h0;

        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST_N = 1'b1;

        fill_all();

        // Byte merge with write-first visibility on the same edge.
        cyc(1'b1, 1'b0, 4'hF, 4'd5, 32'h11223344, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'b0101, 4'd5, 32'hAABBCCDD, 4'h0, 1'b0, 1'b0);
        check("merge_same_cycle", {dop_wf, do_wf}, {4'hA, 32'h11BB33DD});
        idle();
        rd(4'd5);
        check("merge_readback", {dop_wf, do_wf}, {4'hA, 32'h11BB33DD});

        // Write modes on addr 7.
        cyc(1'b1, 1'b0, 4'hF, 4'd7, 32'h1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'hF, 4'd7, 32'h2, 4'h0, 1'b0, 1'b0);
        check("mode_read_first",  {dop_rf, do_rf}, 36'h1);
        check("mode_write_first", {dop_wf, do_wf}, 36'h2);

        // Output register latency, freeze and SSR.
        cyc(1'b1, 1'b0, 4'hF, 4'd3, 32'hCAFEF00D, 4'h0, 1'b0, 1'b0);
        rd(4'd9);
        rd(4'd3);
        cyc(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("doreg_two_edges", {dop_rg, do_rg}, 36'h0_CAFEF00D);
        cyc(1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 4'h0, 1'b0, 1'b0);
        check("doreg_frozen", {dop_rg, do_rg}, 36'h0_CAFEF00D);
        cyc(1'b0, 1'b1, 4'h0, 4'd0, 32'h0, 4'h0, 1'b1, 1'b0);
        check("doreg_ssr", {dop_rg, do_rg}, SRVAL_V);

        // Full clear with a write attempt mid-sweep.
        cyc(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) cyc(1'b1, 1'b0, 4'hF, 4'd2, 32'h77777777, 4'hF, 1'b1, 1'b1);
            else        idle();
        end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            check("clear_word", {dop_wf, do_wf}, CLR_V);
        end

        // Reset during the sweep.
        fill_all();
        cyc(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b1);
        repeat (6) idle();
        @(negedge CLK);
        EN = 1'b0; WE = 4'h0; SSR = 1'b0; REGCE = 1'b0; CLR = 1'b0;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_all();
        check("abort_busy", {35'h0, busy_wf}, 36'h0);
        check("abort_init", {dop_wf, do_wf}, INIT_V);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            if (a < 6) check("abort_cleared", {dop_wf, do_wf}, CLR_V);
        end

        // CLR in the same cycle as a write to addr 0.
        cyc(1'b1, 1'b0, 4'hF, 4'd0, 32'h12345678, 4'h5, 1'b1, 1'b1);
        check("clr_write_commits", {dop_wf, do_wf}, 36'h5_12345678);
        repeat (16) idle();
        rd(4'd0);
        check("clr_overwrites_0", {dop_wf, do_wf}, CLR_V);

        // Randomized traffic.
        fill_all();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3) != 0, $urandom_range(7) == 0, 4'($urandom_range(15)),
                4'($urandom_range(15)), $urandom, 4'($urandom_range(15)),
                1'($urandom_range(1)), $urandom_range(60) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
